// File: rtl/psg_pkg.sv
// Shared constants and register-map helpers for the PSG tone bank.
package psg_pkg;

    typedef enum logic [1:0] {
        BUS_IDLE  = 2'b00,
        BUS_READ  = 2'b01,
        BUS_WRITE = 2'b10,
        BUS_LATCH = 2'b11
    } bus_mode_e;

    localparam int          LFSR_BITS  = 17;
    localparam logic [16:0] LFSR_SEED  = 17'h00001;
    localparam int          LFSR_TAP   = 3;
    localparam int          NOISE_BITS = 5;

    function automatic logic [3:0] reg_period_lo(input int i);
        return 4'(2 * i);
    endfunction

    function automatic logic [3:0] reg_period_hi(input int i);
        return 4'(2 * i + 1);
    endfunction

    function automatic logic [3:0] reg_noise(input int n);
        return 4'(2 * n);
    endfunction

    function automatic logic [3:0] reg_mixer(input int n);
        return 4'(2 * n + 1);
    endfunction

    function automatic logic [3:0] reg_amp(input int n, input int i);
        return 4'(2 * n + 2 + i);
    endfunction

endpackage

// File: rtl/psg_period_counter.sv
// Tick-driven period counter; pulses wrap when the programmed period elapses.
module psg_period_counter #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic [WIDTH-1:0] period,
    output logic             wrap
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] eff;
    logic [WIDTH:0]   next;

    // >= rather than == so a period lowered below count wraps at once.
    always_comb begin
        eff  = (period == '0) ? WIDTH'(1) : period;
        next = {1'b0, count} + (WIDTH+1)'(1);
        wrap = tick && (next >= {1'b0, eff});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (tick) begin
            count <= wrap ? '0 : next[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/psg_tone_bank.sv
// Programmable tone/noise bank with latched-address bus and amplitude mixer.
module psg_tone_bank
    import psg_pkg::*;
#(
    parameter int NUM_CHANNELS = 3,
    parameter int PERIOD_BITS  = 12,
    parameter int AMP_BITS     = 4,
    parameter int PRESCALE     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              bus_mode,
    input  logic [7:0]              bus_data_in,
    output logic [7:0]              bus_data_out,
    output logic                    bus_data_oe,
    output logic [NUM_CHANNELS-1:0] channel_out,
    output logic [AMP_BITS+1:0]     sample_out
);

    localparam int N       = NUM_CHANNELS;
    localparam int HI_BITS = PERIOD_BITS - 8;
    localparam int PS_BITS = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [1:0] rst_pipe;
    logic       rst_sync_n;

    logic [PERIOD_BITS-1:0] period [N];
    logic [AMP_BITS:0]      amp [N];
    logic [NOISE_BITS-1:0]  noise_period;
    logic [N-1:0]           tone_dis;
    logic [N-1:0]           noise_dis;
    logic [3:0]             addr;

    logic [PS_BITS-1:0]     pre;
    logic                   tick;
    logic [N-1:0]           tone_wrap;
    logic [N-1:0]           tone;
    logic                   noise_wrap;
    logic [LFSR_BITS-1:0]   lfsr;

    logic [7:0]             rdata;
    logic [7:0]             mixer_val;
    logic [AMP_BITS+1:0]    sum;

    // Assert immediately, release on a clock edge so all state exits together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_sync_n = rst_pipe[1];

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            addr <= '0;
        end else if (bus_mode == BUS_LATCH) begin
            addr <= bus_data_in[3:0];
        end
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            for (int i = 0; i < N; i++) begin
                period[i] <= '0;
                amp[i]    <= '0;
            end
            noise_period <= '0;
            tone_dis     <= '0;
            noise_dis    <= '0;
        end else if (bus_mode == BUS_WRITE) begin
            for (int i = 0; i < N; i++) begin
                if (addr == reg_period_lo(i))
                    period[i][7:0] <= bus_data_in;
                if (addr == reg_period_hi(i))
                    period[i][PERIOD_BITS-1:8] <= bus_data_in[HI_BITS-1:0];
                if (addr == reg_amp(N, i))
                    amp[i] <= bus_data_in[AMP_BITS:0];
            end
            if (addr == reg_noise(N))
                noise_period <= bus_data_in[NOISE_BITS-1:0];
            if (addr == reg_mixer(N)) begin
                tone_dis  <= bus_data_in[N-1:0];
                noise_dis <= bus_data_in[N+3:4];
            end
        end
    end

    always_comb begin
        mixer_val        = '0;
        mixer_val[N-1:0] = tone_dis;
        mixer_val[N+3:4] = noise_dis;
        rdata            = 8'h00;
        for (int i = 0; i < N; i++) begin
            if (addr == reg_period_lo(i))
                rdata = period[i][7:0];
            if (addr == reg_period_hi(i))
                rdata = 8'(period[i][PERIOD_BITS-1:8]);
            if (addr == reg_amp(N, i))
                rdata = 8'(amp[i]);
        end
        if (addr == reg_noise(N))
            rdata = 8'(noise_period);
        if (addr == reg_mixer(N))
            rdata = mixer_val;
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            bus_data_oe  <= 1'b0;
            bus_data_out <= 8'h00;
        end else if (bus_mode == BUS_READ) begin
            bus_data_oe  <= 1'b1;
            bus_data_out <= rdata;
        end else begin
            bus_data_oe  <= 1'b0;
            bus_data_out <= 8'h00;
        end
    end

    assign tick = (pre == PS_BITS'(PRESCALE - 1));

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + PS_BITS'(1);
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_tone
        psg_period_counter #(
            .WIDTH (PERIOD_BITS)
        ) u_cnt (
            .clk    (clk),
            .rst_n  (rst_sync_n),
            .tick   (tick),
            .period (period[g]),
            .wrap   (tone_wrap[g])
        );
    end

    psg_period_counter #(
        .WIDTH (NOISE_BITS)
    ) u_noise (
        .clk    (clk),
        .rst_n  (rst_sync_n),
        .tick   (tick),
        .period (noise_period),
        .wrap   (noise_wrap)
    );

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            tone <= '0;
            lfsr <= LFSR_SEED;
        end else begin
            tone <= tone ^ tone_wrap;
            if (noise_wrap)
                lfsr <= {lfsr[0] ^ lfsr[LFSR_TAP], lfsr[LFSR_BITS-1:1]};
        end
    end

    assign channel_out = (tone | tone_dis) & ({N{lfsr[0]}} | noise_dis);

    always_comb begin
        sum = '0;
        for (int i = 0; i < N; i++) begin
            if (channel_out[i])
                sum = sum + (AMP_BITS+2)'(amp[i][AMP_BITS-1:0]);
        end
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            sample_out <= '0;
        end else begin
            sample_out <= sum;
        end
    end

endmodule

// File: tb/tb_psg_tone_bank.sv
// Directed self-checking bench for psg_tone_bank (default parameters).
module tb_psg_tone_bank;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] bus_mode = 2'b00;
    logic [7:0] bus_data_in = 8'h00;
    logic [7:0] bus_data_out;
    logic       bus_data_oe;
    logic [2:0] channel_out;
    logic [5:0] sample_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    psg_tone_bank dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus_mode     (bus_mode),
        .bus_data_in  (bus_data_in),
        .bus_data_out (bus_data_out),
        .bus_data_oe  (bus_data_oe),
        .channel_out  (channel_out),
        .sample_out   (sample_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        bus_mode = 2'b00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic latch_write(input logic [3:0] a, input logic [7:0] d);
        bus_mode = 2'b11;
        bus_data_in = {4'h0, a};
        @(negedge clk);
        bus_mode = 2'b10;
        bus_data_in = d;
        @(negedge clk);
        bus_mode = 2'b00;
    endtask

    task automatic read_check(input logic [3:0] a, input logic [7:0] exp,
                              input string tag);
        bus_mode = 2'b11;
        bus_data_in = {4'h0, a};
        @(negedge clk);
        bus_mode = 2'b01;
        @(negedge clk);
        bus_mode = 2'b00;
        check({tag, " data"}, 32'(bus_data_out), 32'(exp));
        check({tag, " oe"}, 32'(bus_data_oe), 32'd1);
        @(negedge clk);
        check({tag, " oe drop"}, 32'(bus_data_oe), 32'd0);
        check({tag, " data drop"}, 32'(bus_data_out), 32'd0);
    endtask

    task automatic wait_toggle(input int budget, input string tag,
                               output int t);
        logic p;
        int n;
        p = channel_out[0];
        n = 0;
        while (channel_out[0] === p && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (n < budget) else begin
            errors++;
            $error("FAIL %s: observed no toggle in %0d cycles expected toggle",
                   tag, budget);
        end
        t = cyc;
    endtask

    task automatic wait_chan(input logic [2:0] v, input int budget,
                             input string tag);
        int n;
        n = 0;
        while (channel_out !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(channel_out), 32'(v));
    endtask

    initial begin
        int t1, t2, t3;
        logic [19:0] golden;
        // x0 = 1, x1..x16 = 0, x17 = x0^x3 = 1, x18 = x19 = 0
        golden = 20'b0010_0000_0000_0000_0001;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst oe", 32'(bus_data_oe), 32'd0);
        check("rst data", 32'(bus_data_out), 32'd0);
        check("rst sample", 32'(sample_out), 32'd0);
        check("rst chan", 32'(channel_out), 32'd0);
        check("rst lfsr", 32'(dut.lfsr), 32'h1);
        do_reset();

        latch_write(4'd6, 8'd31);
        latch_write(4'd8, 8'd15);
        latch_write(4'd9, 8'd15);
        latch_write(4'd10, 8'd15);
        latch_write(4'd7, 8'h3F);
        check("mix3f chan", 32'(channel_out), 32'h7);
        @(negedge clk);
        check("mix3f sample", 32'(sample_out), 32'd45);
        latch_write(4'd7, 8'h07);
        check("mix07 chan", 32'(channel_out), 32'h7);
        wait_chan(3'b000, 800, "noise low chan");
        @(negedge clk);
        check("all low sample", 32'(sample_out), 32'd0);
        latch_write(4'd7, 8'h17);
        check("mix17 chan", 32'(channel_out), 32'h1);
        @(negedge clk);
        check("mix17 sample", 32'(sample_out), 32'd15);
        latch_write(4'd8, 8'h1F);
        read_check(4'd8, 8'h1F, "amp0 env");
        check("env sample", 32'(sample_out), 32'd15);

        latch_write(4'd1, 8'hFF);
        read_check(4'd1, 8'h0F, "hi mask");
        read_check(4'd15, 8'h00, "unmapped");
        read_check(4'd7, 8'h17, "mixer rd");

        latch_write(4'd7, 8'h38);
        latch_write(4'd0, 8'h02);
        latch_write(4'd1, 8'h00);
        wait_toggle(100, "p2 t1", t1);
        wait_toggle(100, "p2 t2", t2);
        check("period2 half", 32'(t2 - t1), 32'd32);

        latch_write(4'd0, 8'h00);
        wait_toggle(100, "p0 t1", t1);
        wait_toggle(100, "p0 t2", t2);
        check("period0 half", 32'(t2 - t1), 32'd16);

        latch_write(4'd1, 8'h01);
        latch_write(4'd0, 8'h2C);
        wait_toggle(6000, "p300 t1", t1);
        repeat (3202) @(negedge clk);
        latch_write(4'd0, 8'h05);
        latch_write(4'd1, 8'h00);
        wait_toggle(100, "p5 t2", t2);
        check("lowered wrap", 32'(t2 - t1), 32'd3216);
        wait_toggle(200, "p5 t3", t3);
        check("period5 half", 32'(t3 - t2), 32'd80);

        latch_write(4'd7, 8'h07);
        repeat (40) @(negedge clk);
        bus_mode = 2'b11;
        bus_data_in = 8'h02;
        @(negedge clk);
        bus_mode = 2'b01;
        @(negedge clk);
        rst_n = 1'b0;
        bus_mode = 2'b00;
        #1;
        check("midrst lfsr", 32'(dut.lfsr), 32'h1);
        check("midrst sample", 32'(sample_out), 32'd0);
        check("midrst oe", 32'(bus_data_oe), 32'd0);
        check("midrst data", 32'(bus_data_out), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        latch_write(4'd7, 8'h07);
        check("noise bit 0", 32'(channel_out), 32'h7);
        wait_chan(3'b000, 40, "noise first shift");
        repeat (8) @(negedge clk);
        for (int k = 1; k < 20; k++) begin
            check($sformatf("noise bit %0d", k),
                  32'(channel_out[0]), 32'(golden[k]));
            repeat (16) @(negedge clk);
        end

        bus_mode = 2'b11;
        bus_data_in = 8'h02;
        @(negedge clk);
        rst_n = 1'b0;
        bus_mode = 2'b10;
        bus_data_in = 8'hAA;
        repeat (3) @(negedge clk);
        bus_mode = 2'b00;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        bus_mode = 2'b10;
        bus_data_in = 8'h55;
        @(negedge clk);
        bus_mode = 2'b00;
        read_check(4'd0, 8'h55, "postrst addr0");
        read_check(4'd2, 8'h00, "postrst addr2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/psg_tone_bank.md
PSG_TONE_BANK -- requirements
Module: psg_tone_bank

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 3: tone channels; legal range 1..4.
REQ-002 SHALL have parameter PERIOD_BITS, default 12: tone period width; legal range 9..16.
REQ-003 SHALL have parameter AMP_BITS, default 4: channel amplitude width.
REQ-004 SHALL have parameter PRESCALE, default 16: clk cycles per generator tick; minimum 1.
REQ-005 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset is asynchronous and active-low.
REQ-007 SHALL have port bus_mode, input, 2: 00 idle, 01 read, 10 write, 11 latch address.
REQ-008 SHALL have port bus_data_in, input, 8: address (latch) or write data.
REQ-009 SHALL have port bus_data_out, output, 8: registered read data.
REQ-010 SHALL have port bus_data_oe, output, 1: high while bus_data_out carries read data.
REQ-011 SHALL have port channel_out, output, NUM_CHANNELS: post-mixer 1-bit channel state.
REQ-012 SHALL have port sample_out, output, AMP_BITS+2: registered sum of active channel amplitudes.

Function
REQ-013 Register map, N=NUM_CHANNELS: 2i = period[i] low 8 bits; 2i+1 = period[i] high bits (zero-extended); 2N = noise period [4:0]; 2N+1 = mixer (bits [N-1:0] tone disable, bits [N+3:4] noise disable); 2N+2+i = amplitude[i] [AMP_BITS:0] (top bit envelope flag, stored only).
REQ-014 bus_mode=11: latched address <= bus_data_in[3:0]; no register changes.
REQ-015 bus_mode=10: register at latched address <= bus_data_in masked to its width; unmapped addresses ignored; latched address unchanged.
REQ-016 bus_mode=01: next cycle bus_data_oe=1, bus_data_out = addressed register zero-extended; unmapped reads return 8'h00; otherwise bus_data_oe=0, bus_data_out=8'h00.
REQ-017 Prescaler counts 0..PRESCALE-1; tick asserted one cycle at PRESCALE-1, then wraps to 0.
REQ-018 Effective period = programmed period, with 0 treated as 1; applies to tone and noise.
REQ-019 On tick, each tone counter: if counter+1 >= effective period then counter <= 0 and tone toggles, else counter increments.
REQ-020 Period lowered below current counter SHALL wrap at next tick (>= comparison), never run to counter overflow.
REQ-021 Noise counter as REQ-019 using noise period; on wrap, 17-bit LFSR shifts right, new MSB = lfsr[0] XOR lfsr[3]; noise bit = lfsr[0].
REQ-022 channel_out[i] = (tone[i] | tone_disable[i]) & (noise | noise_disable[i]).
REQ-023 sample_out <= sum over i of (channel_out[i] ? amplitude[i][AMP_BITS-1:0] : 0), one-cycle latency, no overflow (width sufficient for N<=4).
REQ-024 Register written in cycle T SHALL be used by generators from cycle T+1.

Reset
REQ-025 rst_n low SHALL immediately clear all registers, latched address, prescaler, counters, tone bits, sample_out, bus_data_out, bus_data_oe.
REQ-026 LFSR SHALL reset to 17'h00001.
REQ-027 Reset asserted mid-transaction SHALL discard the transaction; first post-reset write requires a new latch.
REQ-028 Release of rst_n SHALL be synchronised before use so all state leaves reset on the same clk edge.

Structure
REQ-029 Shared package psg_pkg SHALL hold bus_mode encodings, LFSR width/seed/tap constants, and register-offset functions of NUM_CHANNELS.
REQ-030 Sub-module psg_period_counter (period input, tick, wrap output) SHALL be instantiated once per tone channel and once for noise.

Verification
REQ-031 Latch 0, write 8'h02, latch 1, write 8'h00, PRESCALE=16, mixer 8'h38 -> channel_out[0] toggles every 32 clk.
REQ-032 Period 0 on channel 0 -> toggles every 16 clk, identical to period 1.
REQ-033 Counter at 200, rewrite period to 5 -> wrap at next tick, then 5-tick half-periods.
REQ-034 Write amplitude regs 15,15,15, mixer 8'h3F -> sample_out=45 one cycle after all channel_out high; 0 when all low.
REQ-035 Write 8'hFF to address 1, read back -> 8'h0F with bus_data_oe=1 exactly one cycle; read address 15 -> 8'h00.
REQ-036 Reset pulse during noise run -> LFSR=17'h00001, sample_out=0, bus_data_oe=0 immediately; first 17 noise bits match golden sequence.
